// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests, buffers the
// in-order responses in a small FIFO and presents the head instruction
// together with its address + 4. A taken branch flushes the FIFO, redirects
// fetching and discards every response still in flight from the old path.
// Optional macro IF_PERF_CNT_EN adds pop / flush event counters.
module instruction_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              freeze,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count,
`endif
  output logic [ADDR_W-1:0] pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;     // address of the next kept response
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_cnt_q, discard_cnt_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

  logic [DATA_W-1:0] data_mem [QDEPTH];
  logic [ADDR_W-1:0] pc_mem   [QDEPTH];

  logic [CW:0] occ_sum;
  logic        accept;
  logic        drop;
  logic        push;
  logic        pop;

  // Handshake decode: request gating, response keep/drop, head pop
  always_comb begin
    occ_sum       = {1'b0, count_q} + {1'b0, outstanding_q};
    mem_req_valid = (occ_sum < (CW+1)'(QDEPTH)) && !rst && !branch_taken;
    mem_req_addr  = fetch_pc_q;
    accept        = mem_req_valid && mem_req_ready;
    drop          = mem_rsp_valid && (discard_cnt_q != '0);
    push          = mem_rsp_valid && !drop && !branch_taken;
    instr_valid   = (count_q != '0);
    pop           = instr_valid && !freeze && !branch_taken;
    instruction   = instr_valid ? data_mem[rd_ptr_q] : '0;
    pc            = instr_valid ? pc_mem[rd_ptr_q]   : '0;
  end

  // Next-state: sequential fetch, in-flight tracking, flush on branch
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_cnt_d = discard_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(mem_rsp_valid);
    if (accept) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    if (branch_taken) begin
      // Anything still in flight belongs to the abandoned path.
      fetch_pc_d    = branch_address;
      rsp_pc_d      = branch_address;
      discard_cnt_d = outstanding_q - CW'(mem_rsp_valid);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (drop) begin
        discard_cnt_d = discard_cnt_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Queue storage; contents are only visible while the entry is occupied
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q + ADDR_W'(4);
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Event counters: instructions consumed and redirect cycles
  always_comb begin
    fetch_count_d = fetch_count_q + 32'(pop);
    flush_count_d = flush_count_q + 16'(branch_taken);
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: behavioural in-order memory with
// variable latency, scoreboard of expected {instruction, pc} per accepted
// request, a table of branch redirects and hand-written corner sequences.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        freeze;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instruction_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .freeze         (freeze),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
`ifdef IF_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .flush_count    (flush_count),
`endif
    .pc             (pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  typedef struct {
    logic [31:0] target;
    int          lat;
    bit          rand_ready;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } vec_t;

  pend_t       pend[$];
  exp_t        sb[$];
  vec_t        vecs[5];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc;
  int          lat;
  bit          ready_v, freeze_v, branch_v, rand_ready;
  logic [31:0] baddr_v;
  logic [31:0] exp_fetch_pc;
  int          first_valid_cyc;
  int          n_pops, n_br;
  logic [31:0] hold_instr, hold_pc;
  bit          ok;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, observe #1 later, model the edge.
  task automatic do_cycle();
    exp_t e;
    @(negedge clk);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    mem_req_ready  = rand_ready ? 1'($urandom_range(0, 1)) : ready_v;
    freeze         = freeze_v;
    branch_taken   = branch_v;
    branch_address = baddr_v;
    #1;
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (branch_v) begin
      chk("req_valid_on_branch", {31'b0, mem_req_valid}, 32'd0);
      sb.delete();
      exp_fetch_pc = baddr_v;
      n_br++;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", mem_req_addr, exp_fetch_pc);
        pend.push_back('{mem_req_addr, cyc + lat});
        sb.push_back('{instr_of(exp_fetch_pc), exp_fetch_pc + 32'd4});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (instr_valid && !freeze_v) begin
        n_pops++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h expected no instruction (cycle %0d)", pc, cyc);
        end else begin
          e = sb.pop_front();
          chk("pop_instr", instruction, e.instr);
          chk("pop_pc", pc, e.pc);
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic wait_valid(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      do_cycle();
      if (instr_valid) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no instr_valid expected one within 40 cycles", name);
    end
  endtask

  task automatic do_branch(input logic [31:0] target);
    branch_v = 1'b1;
    baddr_v  = target;
    do_cycle();
    branch_v = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instruction"}, instruction, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
  endtask

  task automatic restart();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    exp_fetch_pc = 32'd0;
    first_valid_cyc = -1;
    n_pops = 0;
    n_br = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 1, 1'b0, 32'h0000_0044, 32'h0000_0048};
    vecs[1] = '{32'h0000_1000, 2, 1'b1, 32'h0000_1004, 32'h0000_1008};
    vecs[2] = '{32'hFFFF_FFFC, 1, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h0000_0080, 3, 1'b1, 32'h0000_0084, 32'h0000_0088};
    vecs[4] = '{32'h0000_7FFC, 2, 1'b0, 32'h0000_8000, 32'h0000_8004};

    rst = 1'b1; branch_taken = 0; branch_address = 0; freeze = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    ready_v = 1; freeze_v = 0; branch_v = 0; rand_ready = 0; baddr_v = 0;
    lat = 1; cyc = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    restart();

    // Sequential fetch at 1-cycle latency: addresses 0,4,8... and valid at cycle 2
    run(10);
    chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);

    // Freeze for 6 cycles: head holds, requests stop at the occupancy limit
    freeze_v = 1'b1;
    do_cycle();
    hold_instr = instruction;
    hold_pc    = pc;
    chk("freeze_valid_start", {31'b0, instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      chk("freeze_hold_instr", instruction, hold_instr);
      chk("freeze_hold_pc", pc, hold_pc);
    end
    chk("freeze_req_stopped", {31'b0, mem_req_valid}, 32'd0);
    freeze_v = 1'b0;
    run(10);

    // Branch with responses in flight at 3-cycle latency
    lat = 3;
    run(10);
    do_branch(32'h0000_0100);
    do_cycle();
    chk("branch_queue_empty", {31'b0, instr_valid}, 32'd0);
    wait_valid("branch", ok);
    if (ok) chk("branch_first_pc", pc, 32'h0000_0104);
    run(8);

    // Branch together with freeze: flush wins, target becomes the head
    lat = 2;
    freeze_v = 1'b1;
    do_branch(32'h0000_0200);
    wait_valid("branch_freeze", ok);
    if (ok) begin
      chk("branch_freeze_pc", pc, 32'h0000_0204);
      chk("branch_freeze_instr", instruction, instr_of(32'h0000_0200));
    end
    freeze_v = 1'b0;
    run(8);

    // Table of redirect targets, latencies and ready patterns
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      rand_ready = vecs[v].rand_ready;
      do_branch(vecs[v].target);
      wait_valid("vec_first", ok);
      if (ok) chk($sformatf("vec%0d_first_pc", v), pc, vecs[v].exp_first);
      wait_valid("vec_second", ok);
      if (ok) chk($sformatf("vec%0d_second_pc", v), pc, vecs[v].exp_second);
      run(6);
    end
    rand_ready = 1'b0;

`ifdef IF_PERF_CNT_EN
    #1;
    chk("fetch_count", fetch_count, 32'(n_pops));
    chk("flush_count", {16'b0, flush_count}, 32'(n_br));
`endif

    // Asynchronous reset in the middle of traffic
    lat = 2;
    run(5);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    pend.delete();
    sb.delete();
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    restart();
    lat = 1;
    run(8);
    chk("restart_first_valid_cycle", 32'(first_valid_cyc), 32'd2);

    // Drain: every accepted request must eventually be delivered
    ready_v = 1'b0;
    for (int i = 0; i < 40 && (sb.size() != 0 || pend.size() != 0); i++) do_cycle();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_mem_empty", 32'(pend.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the PC/address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction width in bits.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning the instruction queue entries; legal values are powers of 2 that are at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 branch_taken  in  1  redirect request from the execute stage.
REQ-008 branch_address  in  ADDR_W  redirect target.
REQ-009 freeze  in  1  downstream stall; holds the queue head.
REQ-010 mem_req_valid  out  1  fetch request valid.
REQ-011 mem_req_ready  in  1  memory accepts request.
REQ-012 mem_req_addr  out  ADDR_W  fetch byte address.
REQ-013 mem_rsp_valid  in  1  response valid; in order, at most one per cycle, never earlier than 1 cycle after acceptance.
REQ-014 mem_rsp_data  in  DATA_W  fetched instruction.
REQ-015 instr_valid  out  1  queue head valid.
REQ-016 instruction  out  DATA_W  queue head instruction.
REQ-017 pc  out  ADDR_W  head instruction address + 4.

Function
REQ-018 SHALL hold fetch_pc; a request is accepted on any cycle where mem_req_valid && mem_req_ready; on acceptance fetch_pc increments by 4 modulo 2^ADDR_W, with wrap from max to 0 allowed.
REQ-019 SHALL drive mem_req_addr = fetch_pc and assert mem_req_valid iff (occupancy + outstanding) < QDEPTH, rst is low, and branch_taken is low.
REQ-020 SHALL count outstanding (accepted, unanswered) requests in a counter of width log2(QDEPTH)+1.
REQ-021 SHALL push mem_rsp_data together with its address+4 into the queue on a non-discarded mem_rsp_valid; the queue never overflows by construction.
REQ-022 SHALL set instr_valid = queue not empty; instruction and pc come from the head register with zero combinational path from mem_rsp_*.
REQ-023 SHALL pop the head when instr_valid && !freeze && !branch_taken; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 SHALL hold the head and all its outputs stable while freeze is high; requests continue until the occupancy limit is reached.
REQ-025 On branch_taken (priority over freeze and pop), SHALL flush the queue, load fetch_pc = branch_address, and load discard_cnt = outstanding minus any response arriving that cycle.
REQ-026 While discard_cnt > 0, SHALL drop each mem_rsp_valid and decrement discard_cnt; new requests are allowed during discard, and their responses are queued normally after the drop count reaches 0.
REQ-027 A branch during a discard SHALL re-load discard_cnt with the current total outstanding.
REQ-028 Latency: first instr_valid SHALL come no earlier than 2 cycles after the target request is accepted (memory latency of 1 plus the queue register).

Reset
REQ-029 While rst is high, SHALL set fetch_pc=RESET_PC, queue empty, outstanding=0, discard_cnt=0, instr_valid=0, mem_req_valid=0, instruction=0, pc=0.
REQ-030 Reset mid-operation SHALL abandon all in-flight requests; responses for them after rst falls are undefined, and the integrating memory is reset together with this block.

Configuration
REQ-031 With IF_PERF_CNT_EN defined, SHALL add outputs fetch_count [31:0] (count of instructions popped) and flush_count [15:0] (count of branch_taken cycles), both reset to 0 and wrapping; without the macro these ports and their counters do not exist.

Verification
REQ-032 Reset, then memory with 1-cycle latency and always ready -> request addresses 0,4,8,...; instr_valid first high at cycle 2; pc sequence 4,8,12.
REQ-033 freeze held for 6 cycles, QDEPTH=4 -> head unchanged; after 4 accepted requests total, mem_req_valid stays low; no response dropped.
REQ-034 branch_taken to 0x100 with 3 outstanding at 3-cycle latency -> queue empties next cycle; 3 responses dropped; first delivered pc=0x104.
REQ-035 branch_taken and freeze high together -> flush happens; next head is the target instruction.
REQ-036 fetch_pc=0xFFFFFFFC with ADDR_W=32 -> next request address is 0x00000000.
REQ-037 IF_PERF_CNT_EN: 10 pops and 2 branches -> fetch_count=10, flush_count=2.
